// File: rtl/data_stream_source_pkg.sv
// data_stream_source_pkg: default sizing, index-counter width and FSM state
// encoding shared by the sample stream source and its buffer.
// Optional feature macro used by this slice: DATA_REPLAY_EN.
package data_stream_source_pkg;

   localparam int DATA_SIZE      = 32;
   localparam int NUMBER_OF_DATA = 10;
   localparam int INDEX_SIZE     = 8;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_STREAM = 2'b01;
   localparam logic [1:0] ST_DONE   = 2'b10;

   // The host may touch the buffer only while no stream is running.
   function automatic logic write_allowed(input logic [1:0] state, input logic in_range);
      return ((state == ST_IDLE) || (state == ST_DONE)) && in_range;
   endfunction

endpackage

// File: rtl/data_stream_source_if.sv
// data_stream_source_if: host write port, go/replay requests and stream outputs
// of the sample stream source. replay_i exists only with DATA_REPLAY_EN.
interface data_stream_source_if
   import data_stream_source_pkg::*;
#(
   parameter int data_size      = DATA_SIZE,
   parameter int number_of_data = NUMBER_OF_DATA
);
   localparam int addr_size = $clog2(number_of_data);

   logic                 wr_en_i;
   logic [addr_size-1:0] wr_addr_i;
   logic [data_size-1:0] wr_data_i;
   logic                 go_i;
`ifdef DATA_REPLAY_EN
   logic                 replay_i;
`endif
   logic                 start_o;
   logic [data_size-1:0] data_o;
   logic                 busy_o;
   logic                 stream_done_o;
   logic                 wr_err_o;

`ifdef DATA_REPLAY_EN
   modport master (output wr_en_i, wr_addr_i, wr_data_i, go_i, replay_i,
                   input  start_o, data_o, busy_o, stream_done_o, wr_err_o);
   modport slave  (input  wr_en_i, wr_addr_i, wr_data_i, go_i, replay_i,
                   output start_o, data_o, busy_o, stream_done_o, wr_err_o);
`else
   modport master (output wr_en_i, wr_addr_i, wr_data_i, go_i,
                   input  start_o, data_o, busy_o, stream_done_o, wr_err_o);
   modport slave  (input  wr_en_i, wr_addr_i, wr_data_i, go_i,
                   output start_o, data_o, busy_o, stream_done_o, wr_err_o);
`endif

endinterface

// File: rtl/data_stream_source_stream_buffer.sv
// data_stream_source_stream_buffer: number_of_data x data_size register file,
// one synchronous write port, one asynchronous read port, asynchronous clear.
module data_stream_source_stream_buffer #(
   parameter int data_size      = 32,
   parameter int number_of_data = 10,
   parameter int addr_size      = 4
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   input  logic                 wr_en,
   input  logic [addr_size-1:0] wr_addr,
   input  logic [data_size-1:0] wr_data,
   input  logic [addr_size-1:0] rd_addr,
   output logic [data_size-1:0] rd_data
);

   logic [data_size-1:0] mem [number_of_data];

   // Storage: cleared on reset, one sample committed per write strobe.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < number_of_data; i++) begin
            mem[i] <= {data_size{1'b0}};
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_stream_source.sv
// data_stream_source: streams a host-written vector of samples in index order,
// one per cycle, with start_o held high for exactly number_of_data cycles.
// Optional feature macro: DATA_REPLAY_EN (re-stream the unchanged buffer).
module data_stream_source
   import data_stream_source_pkg::*;
#(
   parameter int data_size      = DATA_SIZE,
   parameter int number_of_data = NUMBER_OF_DATA
) (
   input logic                 clock_i,
   input logic                 reset_n_i,
   data_stream_source_if.slave bus
);
   localparam int addr_size = $clog2(number_of_data);
   localparam int last_int  = number_of_data - 1;
   localparam logic [addr_size:0]    ADDR_LIMIT = number_of_data[addr_size:0];
   localparam logic [INDEX_SIZE-1:0] LAST_IDX   = last_int[INDEX_SIZE-1:0];

   logic [1:0]            state;
   logic [INDEX_SIZE-1:0] index;
   logic                  start;
   logic [data_size-1:0]  data;
   logic                  busy;
   logic                  done;
   logic                  wr_err;

   logic                  in_range;
   logic                  wr_ok;
   logic                  wr_bad;
   logic                  go_ok;
   logic                  replay_go;
   logic                  launch;
   logic                  last;
   logic [INDEX_SIZE-1:0] index_inc;
   logic [addr_size-1:0]  rd_addr;
   logic [data_size-1:0]  rd_data;
   logic [data_size-1:0]  first_sample;

`ifdef DATA_REPLAY_EN
   logic                  replay_armed;
`endif

   // Request decode: write acceptance, stream launch and next read address.
   always_comb begin
      in_range  = ({1'b0, bus.wr_addr_i} < ADDR_LIMIT);
      wr_ok     = bus.wr_en_i && write_allowed(state, in_range);
      wr_bad    = bus.wr_en_i && !write_allowed(state, in_range);
      go_ok     = bus.go_i && ((state == ST_IDLE) || (state == ST_DONE));
`ifdef DATA_REPLAY_EN
      replay_go = bus.replay_i && replay_armed && (state == ST_DONE) && !bus.go_i && !wr_ok;
`else
      replay_go = 1'b0;
`endif
      launch    = go_ok || replay_go;
      last      = (index == LAST_IDX);
      index_inc = index + 8'd1;
      if (launch) begin
         rd_addr = {addr_size{1'b0}};
      end else if (last) begin
         rd_addr = index[addr_size-1:0];
      end else begin
         rd_addr = index_inc[addr_size-1:0];
      end
      // A same-cycle write to slot 0 has not reached the buffer yet.
      if (wr_ok && (bus.wr_addr_i == {addr_size{1'b0}})) begin
         first_sample = bus.wr_data_i;
      end else begin
         first_sample = rd_data;
      end
   end

   data_stream_source_stream_buffer #(
      .data_size      (data_size),
      .number_of_data (number_of_data),
      .addr_size      (addr_size)
   ) u_buffer (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .wr_en     (wr_ok),
      .wr_addr   (bus.wr_addr_i),
      .wr_data   (bus.wr_data_i),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   // Stream FSM, index counter and registered outputs.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state  <= ST_IDLE;
         index  <= {INDEX_SIZE{1'b0}};
         start  <= 1'b0;
         data   <= {data_size{1'b0}};
         busy   <= 1'b0;
         done   <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         if (wr_bad) begin
            wr_err <= 1'b1;
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (launch) begin
                  state <= ST_STREAM;
                  index <= {INDEX_SIZE{1'b0}};
                  start <= 1'b1;
                  data  <= first_sample;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (last) begin
                  state <= ST_DONE;
                  index <= {INDEX_SIZE{1'b0}};
                  start <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  index <= index_inc;
                  data  <= rd_data;
               end
            end
            default: begin
               state <= ST_IDLE;
               index <= {INDEX_SIZE{1'b0}};
               start <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DATA_REPLAY_EN
   // Replay eligibility: armed by go_i, revoked by any accepted write.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         replay_armed <= 1'b0;
      end else if (go_ok) begin
         replay_armed <= 1'b1;
      end else if (wr_ok) begin
         replay_armed <= 1'b0;
      end
   end
`endif

   assign bus.start_o       = start;
   assign bus.data_o        = data;
   assign bus.busy_o        = busy;
   assign bus.stream_done_o = done;
   assign bus.wr_err_o      = wr_err;

endmodule

// File: tb/tb_data_stream_source.sv
// tb_data_stream_source: directed self-checking bench for data_stream_source.
module tb_data_stream_source;

   localparam int DS = 32;
   localparam int N  = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_stream_source_if #(.data_size(DS), .number_of_data(N)) bus();

   data_stream_source #(.data_size(DS), .number_of_data(N)) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   int checks = 0;
   int fails  = 0;

   // Q16.16 samples
   logic [31:0] vec1 [N] = '{32'h0005_0000, 32'hFFFD_0000, 32'h0009_0000, 32'h0000_0000,
                             32'h0001_0000, 32'h0002_0000, 32'h0007_0000, 32'hFFF8_0000,
                             32'h0004_0000, 32'h0006_0000};
   logic [31:0] vec2 [N] = '{32'hFFF9_0000, 32'hFFFE_0000, 32'hFFF7_0000, 32'hFFFF_0000,
                             32'hFFFC_0000, 32'hFFFD_0000, 32'hFFFA_0000, 32'hFFFB_0000,
                             32'hFFF8_0000, 32'hFFF6_0000};

   logic [31:0] cap_data [16];
   int          cap_len;

   // Downstream max-search model fed by the stream, sampled mid-cycle.
   logic signed [31:0] ms_max    = 32'sd0;
   logic               ms_active = 1'b0;
   logic               ms_done   = 1'b0;
   always @(negedge clk) begin
      if (bus.start_o) begin
         if (!ms_active) begin
            ms_max    <= bus.data_o;
            ms_active <= 1'b1;
            ms_done   <= 1'b0;
         end else if ($signed(bus.data_o) > ms_max) begin
            ms_max <= bus.data_o;
         end
      end else if (ms_active) begin
         ms_active <= 1'b0;
         ms_done   <= 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic write_word(input logic [3:0] a, input logic [31:0] d);
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = a;
      bus.wr_data_i = d;
      @(posedge clk); #1;
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic load_vec1();
      for (int i = 0; i < N; i++) write_word(i[3:0], vec1[i]);
   endtask

   task automatic load_vec2();
      for (int i = 0; i < N; i++) write_word(i[3:0], vec2[i]);
   endtask

   task automatic pulse_go();
      bus.go_i = 1'b1;
      @(posedge clk); #1;
      bus.go_i = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Records the stream; optionally drives one host write at capture cycle inj_cycle.
   task automatic capture(input int inj_cycle, input logic [3:0] inj_addr, input logic [31:0] inj_data);
      cap_len = 0;
      for (int c = 0; c < N + 6; c++) begin
         if (bus.start_o) begin
            if (cap_len < 16) cap_data[cap_len] = bus.data_o;
            cap_len++;
         end else if (cap_len > 0) begin
            break;
         end
         if (c == inj_cycle) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_addr_i = inj_addr;
            bus.wr_data_i = inj_data;
         end
         @(posedge clk); #1;
         bus.wr_en_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (bus.start_o !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", bus.start_o); end
      checks++; if (bus.data_o !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", bus.data_o); end
      checks++; if ({bus.busy_o, bus.stream_done_o, bus.wr_err_o} !== 3'b000) begin
         fails++; $display("FAIL reset_flags: got %b expected 000", {bus.busy_o, bus.stream_done_o, bus.wr_err_o});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      load_vec1();
      pulse_go();
      checks++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL stream_busy: got %b expected 1", bus.busy_o); end
      capture(-1, 4'd0, 32'h0);
      checks++; if (cap_len !== N) begin fails++; $display("FAIL stream_len: got %0d expected %0d", cap_len, N); end
      for (int i = 0; i < N; i++) begin
         checks++; if (cap_data[i] !== vec1[i]) begin fails++; $display("FAIL stream_data[%0d]: got %h expected %h", i, cap_data[i], vec1[i]); end
      end
      checks++; if (bus.stream_done_o !== 1'b1) begin fails++; $display("FAIL stream_done: got %b expected 1", bus.stream_done_o); end
      checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL stream_idle: got %b expected 0", bus.busy_o); end
      checks++; if (bus.data_o !== vec1[N-1]) begin fails++; $display("FAIL stream_hold: got %h expected %h", bus.data_o, vec1[N-1]); end
   endtask

   task automatic test_max_chain();
      load_vec2();
      pulse_go();
      capture(-1, 4'd0, 32'h0);
      @(posedge clk); #1;
      checks++; if (ms_done !== 1'b1) begin fails++; $display("FAIL max_done: got %b expected 1", ms_done); end
      checks++; if (ms_max !== 32'shFFFF_0000) begin fails++; $display("FAIL max_value: got %h expected ffff0000", ms_max); end
   endtask

   task automatic test_wr_err();
      checks++; if (bus.wr_err_o !== 1'b0) begin fails++; $display("FAIL err_initial: got %b expected 0", bus.wr_err_o); end
      pulse_go();
      capture(1, 4'd3, 32'h0000_0055);
      checks++; if (bus.wr_err_o !== 1'b1) begin fails++; $display("FAIL err_stream_write: got %b expected 1", bus.wr_err_o); end
      checks++; if (cap_data[3] !== vec2[3]) begin fails++; $display("FAIL err_stream_data: got %h expected %h", cap_data[3], vec2[3]); end
      pulse_go();
      capture(-1, 4'd0, 32'h0);
      checks++; if (cap_data[3] !== vec2[3]) begin fails++; $display("FAIL err_buffer_kept: got %h expected %h", cap_data[3], vec2[3]); end
      pulse_reset();
      checks++; if (bus.wr_err_o !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b expected 0", bus.wr_err_o); end
      write_word(4'd12, 32'h0000_00AA);
      checks++; if (bus.wr_err_o !== 1'b1) begin fails++; $display("FAIL err_range: got %b expected 1", bus.wr_err_o); end
   endtask

   task automatic test_async_reset();
      load_vec1();
      pulse_go();
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (bus.data_o !== vec1[3]) begin fails++; $display("FAIL areset_pre: got %h expected %h", bus.data_o, vec1[3]); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.start_o, bus.busy_o} !== 2'b00) begin fails++; $display("FAIL areset_ctrl: got %b expected 00", {bus.start_o, bus.busy_o}); end
      checks++; if (bus.data_o !== 32'h0) begin fails++; $display("FAIL areset_data: got %h expected 0", bus.data_o); end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_go();
      capture(-1, 4'd0, 32'h0);
      checks++; if (cap_len !== N) begin fails++; $display("FAIL areset_len: got %0d expected %0d", cap_len, N); end
      for (int i = 0; i < N; i++) begin
         checks++; if (cap_data[i] !== 32'h0) begin fails++; $display("FAIL areset_zero[%0d]: got %h expected 0", i, cap_data[i]); end
      end
   endtask

   task automatic test_forward();
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 4'd0;
      bus.wr_data_i = 32'h0000_1234;
      bus.go_i      = 1'b1;
      @(posedge clk); #1;
      bus.wr_en_i = 1'b0;
      bus.go_i    = 1'b0;
      capture(-1, 4'd0, 32'h0);
      checks++; if (cap_data[0] !== 32'h0000_1234) begin fails++; $display("FAIL fwd_first: got %h expected 00001234", cap_data[0]); end
      checks++; if (cap_data[1] !== 32'h0) begin fails++; $display("FAIL fwd_second: got %h expected 0", cap_data[1]); end
      checks++; if (bus.wr_err_o !== 1'b0) begin fails++; $display("FAIL fwd_err: got %b expected 0", bus.wr_err_o); end
      pulse_go();
      capture(-1, 4'd0, 32'h0);
      checks++; if (cap_data[0] !== 32'h0000_1234) begin fails++; $display("FAIL fwd_commit: got %h expected 00001234", cap_data[0]); end
   endtask

`ifdef DATA_REPLAY_EN
   task automatic test_replay();
      logic seen;
      load_vec1();
      pulse_go();
      capture(-1, 4'd0, 32'h0);
      bus.replay_i = 1'b1;
      @(posedge clk); #1;
      bus.replay_i = 1'b0;
      capture(-1, 4'd0, 32'h0);
      checks++; if (cap_len !== N) begin fails++; $display("FAIL replay_len: got %0d expected %0d", cap_len, N); end
      for (int i = 0; i < N; i++) begin
         checks++; if (cap_data[i] !== vec1[i]) begin fails++; $display("FAIL replay_data[%0d]: got %h expected %h", i, cap_data[i], vec1[i]); end
      end
      write_word(4'd2, 32'h0000_0077);
      bus.replay_i = 1'b1;
      @(posedge clk); #1;
      bus.replay_i = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bus.start_o) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 1'b0) begin fails++; $display("FAIL replay_blocked: got %b expected 0", seen); end
   endtask
`endif

   initial begin
      bus.wr_en_i   = 1'b0;
      bus.wr_addr_i = 4'd0;
      bus.wr_data_i = 32'h0;
      bus.go_i      = 1'b0;
`ifdef DATA_REPLAY_EN
      bus.replay_i  = 1'b0;
`endif
      test_reset();
      test_stream();
      test_max_chain();
      test_wr_err();
      test_async_reset();
      test_forward();
`ifdef DATA_REPLAY_EN
      test_replay();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
